// File: rtl/video_mode_loader.sv
// Loads one of four display timing modes into the video register bank over the shared register port.
// Optional readback verify of every write: define VIDEO_MODE_LOADER_VERIFY_EN.
module video_mode_loader #(
    parameter logic [23:0] BG_COLOR       = 24'h000000,
    parameter int unsigned VERIFY_RETRIES = 0
) (
    input  logic        mem_clk,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  mode_i,
    input  logic        depth_i,
    input  logic [63:0] base_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [11:0] mem_addr_o,
    output logic [31:0] mem_wrdata_o,
    input  logic [31:0] mem_rddata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [11:0] err_addr_o
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WRITE, S_READ, S_CHECK, S_DONE} state_e;
    localparam logic [4:0] LAST_IDX  = 5'd18;
    localparam logic [4:0] N_ENTRIES = 5'd19;

    if (VERIFY_RETRIES != 0) begin : g_bad_retries
        $error("video_mode_loader: VERIFY_RETRIES must be 0");
    end

    state_e      r_state, w_next;
    logic [4:0]  r_idx;
    logic [1:0]  r_mode;
    logic        r_depth;
    logic [63:0] r_base;
    logic        w_adv, w_access, w_start;
    logic [5:0]  w_word;
    logic [31:0] w_data;
    logic [7:0]  w_freq;
    logic [1:0]  w_pol;
    logic [10:0] w_ht, w_hd, w_hs, w_he, w_vt, w_vd, w_vs, w_ve;
    logic [13:0] w_bpl;

    assign w_start = (r_state == S_IDLE) && start_i;

    always_comb begin
        case (r_mode)
            2'd0: begin
                w_freq = 8'd25; w_pol = 2'b11;
                {w_ht, w_hd, w_hs, w_he} = {11'd800, 11'd640, 11'd656, 11'd752};
                {w_vt, w_vd, w_vs, w_ve} = {11'd525, 11'd480, 11'd490, 11'd492};
            end
            2'd1: begin
                w_freq = 8'd40; w_pol = 2'b00;
                {w_ht, w_hd, w_hs, w_he} = {11'd1056, 11'd800, 11'd840, 11'd968};
                {w_vt, w_vd, w_vs, w_ve} = {11'd628, 11'd600, 11'd601, 11'd605};
            end
            2'd2: begin
                w_freq = 8'd65; w_pol = 2'b11;
                {w_ht, w_hd, w_hs, w_he} = {11'd1344, 11'd1024, 11'd1048, 11'd1184};
                {w_vt, w_vd, w_vs, w_ve} = {11'd806, 11'd768, 11'd771, 11'd777};
            end
            default: begin
                w_freq = 8'd74; w_pol = 2'b00;
                {w_ht, w_hd, w_hs, w_he} = {11'd1650, 11'd1280, 11'd1390, 11'd1430};
                {w_vt, w_vd, w_vs, w_ve} = {11'd750, 11'd720, 11'd725, 11'd730};
            end
        endcase
    end

    // Bytes per line: hdisp * 4 or * 2, kept 8-byte aligned.
    assign w_bpl = (r_depth ? {2'b00, w_hd, 1'b0} : {1'b0, w_hd, 2'b00}) & 14'h3FF8;

    always_comb begin
        w_word = 6'h03;
        w_data = '0;
        case (r_idx)
            5'd0:  begin w_word = 6'h03; w_data = '0;                   end
            5'd1:  begin w_word = 6'h02; w_data = {31'd0, r_depth};     end
            5'd2:  begin w_word = 6'h04; w_data = {30'd0, w_pol};       end
            5'd3:  begin w_word = 6'h05; w_data = {24'd0, w_freq};      end
            5'd4:  begin w_word = 6'h06; w_data = {21'd0, w_hd};        end
            5'd5:  begin w_word = 6'h07; w_data = {21'd0, w_vd};        end
            5'd6:  begin w_word = 6'h08; w_data = {18'd0, w_bpl};       end
            5'd7:  begin w_word = 6'h09; w_data = {8'd0, BG_COLOR};     end
            5'd8:  begin w_word = 6'h00; w_data = r_base[31:0];         end
            5'd9:  begin w_word = 6'h01; w_data = r_base[63:32];        end
            5'd10: begin w_word = 6'h10; w_data = {21'd0, w_ht};        end
            5'd11: begin w_word = 6'h11; w_data = {21'd0, w_hd};        end
            5'd12: begin w_word = 6'h12; w_data = {21'd0, w_hs};        end
            5'd13: begin w_word = 6'h13; w_data = {21'd0, w_he};        end
            5'd14: begin w_word = 6'h14; w_data = {21'd0, w_vt};        end
            5'd15: begin w_word = 6'h15; w_data = {21'd0, w_vd};        end
            5'd16: begin w_word = 6'h16; w_data = {21'd0, w_vs};        end
            5'd17: begin w_word = 6'h17; w_data = {21'd0, w_ve};        end
            default: begin w_word = 6'h03; w_data = 32'd1;              end
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_REQ;
            S_REQ:   w_next = S_WRITE;
`ifdef VIDEO_MODE_LOADER_VERIFY_EN
            S_WRITE: if (bus_gnt_i) w_next = S_READ;
`else
            S_WRITE: if (bus_gnt_i) w_next = (r_idx == LAST_IDX) ? S_DONE : S_WRITE;
`endif
            S_READ:  if (bus_gnt_i) w_next = S_CHECK;
            S_CHECK: w_next = (r_idx == N_ENTRIES) ? S_DONE : S_WRITE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_access     = (r_state == S_WRITE) || (r_state == S_READ);
        bus_req_o    = r_state inside {S_REQ, S_WRITE, S_READ, S_CHECK};
        busy_o       = r_state inside {S_REQ, S_WRITE, S_READ, S_CHECK};
        done_o       = (r_state == S_DONE);
        mem_en_o     = w_access && bus_gnt_i;
        mem_we_o     = (r_state == S_WRITE) ? 4'hF : 4'h0;
        mem_addr_o   = w_access ? {4'd0, w_word, 2'b00} : '0;
        mem_wrdata_o = (r_state == S_WRITE) ? w_data : '0;
    end

    // With verify, an entry is complete only once its readback has been issued.
`ifdef VIDEO_MODE_LOADER_VERIFY_EN
    assign w_adv = (r_state == S_READ) && bus_gnt_i;
`else
    assign w_adv = (r_state == S_WRITE) && bus_gnt_i;
`endif

    always_ff @(posedge mem_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_idx   <= '0;
            r_mode  <= '0;
            r_depth <= 1'b0;
            r_base  <= '0;
        end else if (w_start) begin
            r_idx   <= '0;
            r_mode  <= mode_i;
            r_depth <= depth_i;
            r_base  <= base_i;
        end else if (w_adv) begin
            r_idx <= r_idx + 5'd1;
        end
    end

`ifdef VIDEO_MODE_LOADER_VERIFY_EN
    logic [31:0] r_exp;
    logic [11:0] r_exp_addr, r_err_addr;
    logic        r_cmp, r_err;

    always_ff @(posedge mem_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_exp      <= '0;
            r_exp_addr <= '0;
            r_cmp      <= 1'b0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            if (w_start) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end
            if (w_adv) begin
                r_exp      <= w_data;
                r_exp_addr <= {4'd0, w_word, 2'b00};
                r_cmp      <= (w_word > 6'h01);
            end
            if ((r_state == S_CHECK) && r_cmp && !r_err && (mem_rddata_i != r_exp)) begin
                r_err      <= 1'b1;
                r_err_addr <= r_exp_addr;
            end
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^mem_rddata_i;
    assign err_o       = 1'b0;
    assign err_addr_o  = '0;
`endif
endmodule

// File: tb/tb_video_mode_loader.sv
// Bench for video_mode_loader: table-driven register-sequence model checked every cycle.
`timescale 1ns/1ps
module tb_video_mode_loader;
    localparam logic [23:0] TB_BG = 24'h123456;
`ifdef VIDEO_MODE_LOADER_VERIFY_EN
    localparam int PER = 3;
    localparam int LAG = 2;
`else
    localparam int PER = 1;
    localparam int LAG = 1;
`endif

    logic        mem_clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, depth_i = 1'b0, bus_gnt_i = 1'b1;
    logic [1:0]  mode_i = '0;
    logic [63:0] base_i = '0;
    logic        bus_req_o, mem_en_o, busy_o, done_o, err_o;
    logic [3:0]  mem_we_o;
    logic [11:0] mem_addr_o, err_addr_o;
    logic [31:0] mem_wrdata_o;
    logic [31:0] mem_rddata_i = '0;

    video_mode_loader #(.BG_COLOR(TB_BG), .VERIFY_RETRIES(0)) dut (
        .mem_clk(mem_clk), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
        .depth_i(depth_i), .base_i(base_i), .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wrdata_o(mem_wrdata_o), .mem_rddata_i(mem_rddata_i), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 mem_clk = ~mem_clk;

    // Register-bank responder
    logic [31:0] regs [0:63];
    bit corrupt = 0;
    always @(posedge mem_clk) begin
        if (mem_en_o) begin
            if (mem_we_o == 4'hF) regs[mem_addr_o[7:2]] <= mem_wrdata_o;
            else mem_rddata_i <= (corrupt && mem_addr_o == 12'h040) ? 32'd0 : regs[mem_addr_o[7:2]];
        end
    end

    int unsigned FQ [4] = '{25, 40, 65, 74};
    int unsigned HT [4] = '{800, 1056, 1344, 1650};
    int unsigned HD [4] = '{640, 800, 1024, 1280};
    int unsigned HS [4] = '{656, 840, 1048, 1390};
    int unsigned HE [4] = '{752, 968, 1184, 1430};
    int unsigned VT [4] = '{525, 628, 806, 750};
    int unsigned VD [4] = '{480, 600, 768, 720};
    int unsigned VS [4] = '{490, 601, 771, 725};
    int unsigned VE [4] = '{492, 605, 777, 730};
    int unsigned PL [4] = '{3, 0, 3, 0};
    int unsigned WORDS [19] = '{3, 2, 4, 5, 6, 7, 8, 9, 0, 1, 16, 17, 18, 19, 20, 21, 22, 23, 3};

    typedef struct {logic [11:0] addr; logic we; logic [31:0] data;} acc_t;
    acc_t exp_q [$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, t0 = 0, done_cyc = 0, done_cnt = 0, wr_cnt = 0, m_cd = 0;
    bit m_busy = 0, m_done = 0;
    logic [11:0] last_addr = '0;
    logic [31:0] last_data = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic logic [31:0] entry_val(input int i, input int m, input bit d, input logic [63:0] b);
        int unsigned bpl;
        bpl = ((d ? HD[m] * 2 : HD[m] * 4) % 16384) & 32'h3FF8;
        case (i)
            0:  return 32'd0;
            1:  return {31'd0, d};
            2:  return PL[m];
            3:  return FQ[m];
            4:  return HD[m];
            5:  return VD[m];
            6:  return bpl;
            7:  return {8'd0, TB_BG};
            8:  return b[31:0];
            9:  return b[63:32];
            10: return HT[m];
            11: return HD[m];
            12: return HS[m];
            13: return HE[m];
            14: return VT[m];
            15: return VD[m];
            16: return VS[m];
            17: return VE[m];
            default: return 32'd1;
        endcase
    endfunction

    task automatic load_model(input int m, input bit d, input logic [63:0] b);
        acc_t e;
        exp_q.delete();
        wr_cnt = 0;
        for (int i = 0; i < 19; i++) begin
            e.addr = 12'(WORDS[i] * 4);
            e.we   = 1'b1;
            e.data = entry_val(i, m, d, b);
            exp_q.push_back(e);
`ifdef VIDEO_MODE_LOADER_VERIFY_EN
            e.we = 1'b0;
            exp_q.push_back(e);
`endif
        end
    endtask

    // Compare process
    always @(negedge mem_clk) begin
        acc_t e;
        cyc++;
        if (rst_ni) begin
            m_done = 0;
            if (m_cd > 0) begin
                m_cd--;
                if (m_cd == 0) begin m_done = 1; m_busy = 0; end
            end
            chk("busy", busy_o, m_busy);
            chk("bus_req", bus_req_o, m_busy);
            chk("done", done_o, m_done);
`ifndef VIDEO_MODE_LOADER_VERIFY_EN
            chk("err", err_o, 0);
            chk("err_addr", err_addr_o, 0);
`endif
            if (done_o) begin done_cyc = cyc; done_cnt++; end
            if (!bus_gnt_i || !bus_req_o) chk("en_gated", mem_en_o, 0);
            if (mem_en_o) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_access: addr 0x%0h, expected no access", mem_addr_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", mem_addr_o, e.addr);
                    chk("we", mem_we_o, e.we ? 4'hF : 4'h0);
                    if (e.we) begin
                        chk("wrdata", mem_wrdata_o, e.data);
                        wr_cnt++;
                        last_addr = mem_addr_o;
                        last_data = mem_wrdata_o;
                    end
                    if (exp_q.size() == 0) m_cd = LAG;
                end
            end
`ifndef VIDEO_MODE_LOADER_VERIFY_EN
            else if (!bus_gnt_i && m_busy && wr_cnt > 0 && exp_q.size() > 0) begin
                chk("hold_addr", mem_addr_o, exp_q[0].addr);
                chk("hold_data", mem_wrdata_o, exp_q[0].data);
                chk("hold_we", mem_we_o, 4'hF);
            end
`endif
        end
    end

    task automatic do_start(input int m, input bit d, input logic [63:0] b, input bit model);
        @(posedge mem_clk); #1;
        mode_i = 2'(m); depth_i = d; base_i = b; start_i = 1'b1;
        if (model) load_model(m, d, b);
        @(posedge mem_clk); #1;
        if (model) begin t0 = cyc; m_busy = 1; end
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt, n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin @(posedge mem_clk); #3; n++; end
        if (done_cnt == start_cnt) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic wait_writes(input int target);
        int n;
        n = 0;
        while (wr_cnt < target && n < 200) begin @(posedge mem_clk); #3; n++; end
        if (wr_cnt < target) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout: %0d writes seen, expected %0d", wr_cnt, target);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_req"}, bus_req_o, 0);
        chk({tag, "_en"}, mem_en_o, 0);
        chk({tag, "_we"}, mem_we_o, 0);
        chk({tag, "_addr"}, mem_addr_o, 0);
        chk({tag, "_wrdata"}, mem_wrdata_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_err_addr"}, err_addr_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 32'hDEAD_BEEF;
        @(posedge mem_clk); #1;
        check_idle("reset");
        repeat (2) @(posedge mem_clk);
        #1 rst_ni = 1'b1;

        // Mode 0, 32bpp, base above 4 GiB
        do_start(0, 0, 64'h0000_0001_8000_0000, 1);
        wait_done(100 * PER);
        chk("m0_done_latency", done_cyc - t0 - 1, 1 + 19 * PER);
        chk("m0_writes", wr_cnt, 19);
        chk("m0_bpl", regs[8], 2560);
        chk("m0_base_lo", regs[0], 32'h8000_0000);
        chk("m0_base_hi", regs[1], 32'h1);
        chk("m0_bg", regs[9], 32'h0012_3456);
        chk("m0_htotal", regs[16], 800);
        chk("m0_last_addr", last_addr, 12'h00C);
        chk("m0_last_data", last_data, 1);

        // Mode 3, 16bpp
        do_start(3, 1, 64'h0000_0000_0012_3400, 1);
        wait_done(100 * PER);
        chk("m3_hdisp", regs[6], 1280);
        chk("m3_bpl", regs[8], 2560);
        chk("m3_freq", regs[5], 74);
        chk("m3_pol", regs[4], 0);
        chk("m3_depth", regs[2], 1);
        chk("m3_vsend", regs[23], 730);

        // Grant withdrawn for 5 cycles after the 6th write; resumes at word 08
        do_start(1, 0, 64'h0000_0000_0040_0000, 1);
        wait_writes(6);
        bus_gnt_i = 1'b0;
        repeat (5) @(posedge mem_clk);
        #3 bus_gnt_i = 1'b1;
        wait_done(100 * PER);
        chk("gnt_done_latency", done_cyc - t0 - 1, 1 + 19 * PER + 5);
        chk("gnt_writes", wr_cnt, 19);
        chk("m1_bpl", regs[8], 3200);

        // Start while busy with another mode must be ignored
        do_start(2, 0, 64'h0000_0000_0080_0000, 1);
        repeat (3) @(posedge mem_clk);
        do_start(0, 1, 64'h0000_0000_0000_0008, 0);
        wait_done(100 * PER);
        chk("ign_hdisp", regs[6], 1024);
        chk("ign_freq", regs[5], 65);
        chk("ign_depth", regs[2], 0);
        chk("ign_base_lo", regs[0], 32'h0080_0000);
        repeat (5) @(posedge mem_clk);

        // Reset mid-sequence, then full replay
        do_start(1, 1, 64'h0000_0000_00C0_0000, 1);
        wait_writes(10);
        rst_ni = 1'b0;
        exp_q.delete();
        m_busy = 0;
        m_cd = 0;
        #1 check_idle("midrst");
        @(posedge mem_clk); #1 rst_ni = 1'b1;
        do_start(1, 1, 64'h0000_0002_0100_0000, 1);
        wait_done(100 * PER);
        chk("replay_latency", done_cyc - t0 - 1, 1 + 19 * PER);
        chk("replay_writes", wr_cnt, 19);
        chk("replay_base_hi", regs[1], 32'h2);
        chk("replay_bpl", regs[8], 1600);

`ifdef VIDEO_MODE_LOADER_VERIFY_EN
        corrupt = 1;
        do_start(0, 0, 64'h0000_0000_0000_1000, 1);
        wait_done(100 * PER);
        chk("verify_err", err_o, 1);
        chk("verify_err_addr", err_addr_o, 12'h040);
        chk("verify_writes", wr_cnt, 19);
        corrupt = 0;
        do_start(0, 0, 64'h0000_0000_0000_1000, 1);
        chk("verify_err_cleared", err_o, 0);
        wait_done(100 * PER);
        chk("verify_clean", err_o, 0);
`endif

        repeat (3) @(posedge mem_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
